// File: rtl/nn_layer_seq.sv
// nn_layer_seq: one fully-connected neural-network layer with ReLU.
//   Inputs arrive one per accepted cycle; every neuron multiplies the current
//   input by its own weight and accumulates, all neurons in parallel. After
//   IN_COUNT inputs the bias is added, the result is rescaled and clamped
//   (ReLU with saturation) and the neuron outputs are streamed out, index 0 first.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cfg_wr_en/cfg_addr/cfg_data       weight/bias write port; address
//                                     n*(IN_COUNT+1)+i, i==IN_COUNT is the bias
//   in_valid/in_data/in_ready         serial input stream
//   out_valid/out_data/out_last/out_ready  serial neuron results
//   argmax_valid/argmax_idx           winning-neuron report
// Optional feature: define NN_LAYER_ARGMAX_EN to build the argmax comparator;
// otherwise argmax_valid/argmax_idx are constant 0.
module nn_layer_seq #(
  parameter int NEURONS    = 10,
  parameter int IN_COUNT   = 10,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  localparam int PARAMS    = NEURONS * (IN_COUNT + 1),
  localparam int ADDR_W    = (PARAMS > 1) ? $clog2(PARAMS) : 1,
  localparam int IDX_W     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  argmax_valid,
  output logic [IDX_W-1:0]      argmax_idx
);

  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(IN_COUNT + 1);
  localparam int CNT_W = $clog2(IN_COUNT + 1);
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

  typedef enum logic [2:0] {IDLE, ACCUM, BIAS, ACT, STREAM} state_t;

  state_t                      state_q;
  logic [CNT_W-1:0]            in_cnt_q;
  logic [IDX_W-1:0]            k_q;
  logic [IDX_W-1:0]            k_nxt;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic [DATA_WIDTH-1:0]       out_data_q;
  logic [DATA_WIDTH-1:0]       res_q [NEURONS];
  logic [NEURONS*DATA_WIDTH-1:0] res_all;
  logic                        accept;

  // Parameter storage survives reset on purpose, so it lives in a reset-free block.
  logic [DATA_WIDTH-1:0] param_mem [PARAMS];

  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state_q == IDLE) && (32'(cfg_addr) < 32'(PARAMS)))
      param_mem[cfg_addr] <= cfg_data;
  end

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign k_nxt    = k_q + IDX_W'(1);

  // Per-neuron multiply-accumulate and output activation.
  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(gi * (IN_COUNT + 1));

    logic signed [DATA_WIDTH-1:0]   w_sel;
    logic signed [DATA_WIDTH-1:0]   b_sel;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        bias_ext;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        acc_d;
    logic signed [ACC_W-1:0]        shifted;
    logic [DATA_WIDTH-1:0]          res_d;

    assign w_sel    = signed'(param_mem[BASE + ADDR_W'(in_cnt_q)]);
    assign b_sel    = signed'(param_mem[BASE + ADDR_W'(IN_COUNT)]);
    assign prod     = signed'(in_data) * w_sel;
    assign prod_ext = {{(ACC_W - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    // Bias is a plain fixed-point value; align it with the product scale.
    assign bias_ext = {{(ACC_W - DATA_WIDTH){b_sel[DATA_WIDTH-1]}}, b_sel} <<< FRAC_BITS;
    assign shifted  = acc_q >>> FRAC_BITS;

    always_comb begin
      acc_d = acc_q;
      if (accept && (state_q == IDLE))
        acc_d = prod_ext;            // first input clears and loads in one step
      else if (accept && (state_q == ACCUM))
        acc_d = acc_q + prod_ext;
      else if (state_q == BIAS)
        acc_d = acc_q + bias_ext;
    end

    always_comb begin
      if (shifted[ACC_W-1])
        res_d = '0;
      else if (shifted > RES_MAX)
        res_d = RES_MAX[DATA_WIDTH-1:0];
      else
        res_d = shifted[DATA_WIDTH-1:0];
    end

    assign res_all[gi*DATA_WIDTH +: DATA_WIDTH] = res_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end
  end

`ifdef NN_LAYER_ARGMAX_EN
  logic [IDX_W-1:0]      best_d;
  logic [IDX_W-1:0]      best_q;
  logic [IDX_W-1:0]      held_q;
  logic [DATA_WIDTH-1:0] best_v;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_d = '0;
    best_v = res_all[0 +: DATA_WIDTH];
    for (int n = 1; n < NEURONS; n++) begin
      if (res_all[n*DATA_WIDTH +: DATA_WIDTH] > best_v) begin
        best_v = res_all[n*DATA_WIDTH +: DATA_WIDTH];
        best_d = IDX_W'(n);
      end
    end
  end

  // The pulse follows the final handshake; the index shows the new winner
  // during the pulse and the held copy at all other times.
  assign argmax_valid = out_valid_q && out_ready && out_last_q;
  assign argmax_idx   = argmax_valid ? best_q : held_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
      held_q <= '0;
    end else begin
      if (state_q == ACT) best_q <= best_d;
      if (argmax_valid)   held_q <= best_q;
    end
  end
`else
  assign argmax_valid = 1'b0;
  assign argmax_idx   = '0;
`endif

  // Control FSM. STREAM spends its first cycle loading the output register,
  // so out_valid rises three edges after the last input is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int n = 0; n < NEURONS; n++) res_q[n] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_cnt_q <= CNT_W'(1);
            state_q  <= (IN_COUNT == 1) ? BIAS : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
            if (in_cnt_q == CNT_W'(IN_COUNT - 1)) state_q <= BIAS;
          end
        end
        BIAS: begin
          in_cnt_q <= '0;
          state_q  <= ACT;
        end
        ACT: begin
          for (int n = 0; n < NEURONS; n++) res_q[n] <= res_all[n*DATA_WIDTH +: DATA_WIDTH];
          k_q     <= '0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_q[0];
            out_last_q  <= (NEURONS == 1);
          end else if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              k_q         <= '0;
              state_q     <= IDLE;
            end else begin
              k_q        <= k_nxt;
              out_data_q <= res_q[k_nxt];
              out_last_q <= (k_nxt == IDX_W'(NEURONS - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
